// File: rtl/inst_rom_arbiter_pkg.sv
// Shared constants and types for the instruction-ROM arbiter between IF and LS.
package inst_rom_arbiter_pkg;

  localparam logic      CHIP_ENABLE      = 1'b1;
  localparam logic      CHIP_DISABLE     = 1'b0;
  localparam logic      RST_ENABLE       = 1'b0;
  localparam int        STARVE_LIMIT_DEF = 3;
  localparam int        STARVE_CNT_W     = 2;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_LS   = 2'd2
  } grant_e;

  function automatic logic is_word_aligned(input logic [1:0] i_low);
    return i_low == 2'b00;
  endfunction

endpackage

// File: rtl/inst_rom_arbiter.sv
// Arbitrates the single-ported instruction ROM between IF and LS with LS priority,
// bounded IF starvation, and registered one-cycle-latency responses.
module inst_rom_arbiter
  import inst_rom_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_flush,
  output logic              o_if_gnt,
  output logic              o_if_rvalid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_ls_req,
  input  logic [ADDR_W-1:0] i_ls_addr,
  output logic              o_ls_gnt,
  output logic              o_ls_rvalid,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic              o_ls_err,
  output logic              o_rom_ce,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_inst,
  output logic              o_stallreq
);

  localparam int CNT_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_cnt;
  grant_e           w_grant;
  logic             w_in_reset;
  logic             w_ls_aligned;
  logic             w_if_starved;

  assign w_in_reset   = (i_rst == RST_ENABLE);
  assign w_ls_aligned = is_word_aligned(i_ls_addr[1:0]);
  assign w_if_starved = i_if_req && (r_cnt == CNT_MAX);

  // LS wins unless IF has waited through STARVE_LIMIT consecutive LS grants.
  always_comb begin
    w_grant    = GNT_NONE;
    o_rom_ce   = CHIP_DISABLE;
    o_rom_addr = '0;
    if (!w_in_reset) begin
      if (i_ls_req && !w_if_starved) begin
        w_grant = GNT_LS;
      end else if (i_if_req) begin
        w_grant = GNT_IF;
      end
    end
    if (w_grant == GNT_IF) begin
      o_rom_ce   = CHIP_ENABLE;
      o_rom_addr = i_if_addr;
    end else if (w_grant == GNT_LS && w_ls_aligned) begin
      o_rom_ce   = CHIP_ENABLE;
      o_rom_addr = i_ls_addr;
    end
  end

  assign o_if_gnt   = (w_grant == GNT_IF);
  assign o_ls_gnt   = (w_grant == GNT_LS);
  assign o_stallreq = !w_in_reset && i_ls_req && !o_ls_gnt;

  always_ff @(posedge i_clk) begin
    if (w_in_reset) begin
      r_cnt <= '0;
    end else if (!i_if_req || o_if_gnt) begin
      r_cnt <= '0;
    end else if (o_ls_gnt && r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Responses: rdata only moves when a response is actually delivered.
  always_ff @(posedge i_clk) begin
    if (w_in_reset) begin
      o_if_rvalid <= 1'b0;
      o_if_rdata  <= DATA_W'(ZERO_WORD);
      o_ls_rvalid <= 1'b0;
      o_ls_err    <= 1'b0;
      o_ls_rdata  <= DATA_W'(ZERO_WORD);
    end else begin
      o_if_rvalid <= o_if_gnt && !i_if_flush;
      if (o_if_gnt && !i_if_flush) begin
        o_if_rdata <= i_rom_inst;
      end
      o_ls_rvalid <= o_ls_gnt;
      o_ls_err    <= o_ls_gnt && !w_ls_aligned;
      if (o_ls_gnt) begin
        o_ls_rdata <= w_ls_aligned ? i_rom_inst : DATA_W'(ZERO_WORD);
      end
    end
  end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Randomized plus directed bench for inst_rom_arbiter against a cycle-level reference model.
module tb_inst_rom_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 3;

  logic              clk;
  logic              rst;
  logic              ifReq, ifFlush, lsReq;
  logic [ADDR_W-1:0] ifAddr, lsAddr;
  logic              ifGnt, ifRvalid, lsGnt, lsRvalid, lsErr, romCe, stallReq;
  logic [DATA_W-1:0] ifRdata, lsRdata, romInst;
  logic [ADDR_W-1:0] romAddr;

  logic [DATA_W-1:0] romMem [256];
  assign romInst = romMem[romAddr[9:2]];

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state: registered outputs expected in the current cycle.
  int                lsStreak;
  logic              expIfRvalid, expLsRvalid, expLsErr;
  logic [DATA_W-1:0] expIfRdata, expLsRdata;
  logic              lastIfGnt, lastLsGnt;

  inst_rom_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(ifReq), .i_if_addr(ifAddr), .i_if_flush(ifFlush),
    .o_if_gnt(ifGnt), .o_if_rvalid(ifRvalid), .o_if_rdata(ifRdata),
    .i_ls_req(lsReq), .i_ls_addr(lsAddr),
    .o_ls_gnt(lsGnt), .o_ls_rvalid(lsRvalid), .o_ls_rdata(lsRdata), .o_ls_err(lsErr),
    .o_rom_ce(romCe), .o_rom_addr(romAddr), .i_rom_inst(romInst),
    .o_stallreq(stallReq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] romWord(input logic [ADDR_W-1:0] a);
    return romMem[a[9:2]];
  endfunction

  // Drives one cycle, checks every output against the model, then advances the model.
  task automatic applyStimulus(input logic rstV, input logic ifReqV, input logic [ADDR_W-1:0] ifAddrV,
                               input logic ifFlushV, input logic lsReqV, input logic [ADDR_W-1:0] lsAddrV);
    logic expIfGnt, expLsGnt, lsOk, expCe;
    logic [ADDR_W-1:0] expAddr;
    @(posedge clk);
    #1;
    rst = rstV; ifReq = ifReqV; ifAddr = ifAddrV; ifFlush = ifFlushV; lsReq = lsReqV; lsAddr = lsAddrV;
    #3;
    lsOk     = (lsAddrV % 4) == 0;
    expLsGnt = rstV && lsReqV && !(ifReqV && lsStreak >= STARVE_LIMIT);
    expIfGnt = rstV && ifReqV && !expLsGnt;
    expCe    = expIfGnt || (expLsGnt && lsOk);
    expAddr  = expIfGnt ? ifAddrV : ((expLsGnt && lsOk) ? lsAddrV : '0);
    checkOutput("if_gnt", 32'(ifGnt), 32'(expIfGnt));
    checkOutput("ls_gnt", 32'(lsGnt), 32'(expLsGnt));
    checkOutput("rom_ce", 32'(romCe), 32'(expCe));
    checkOutput("rom_addr", romAddr, expAddr);
    checkOutput("stallreq", 32'(stallReq), 32'(rstV && lsReqV && !expLsGnt));
    checkOutput("if_rvalid", 32'(ifRvalid), 32'(expIfRvalid));
    checkOutput("if_rdata", ifRdata, expIfRdata);
    checkOutput("ls_rvalid", 32'(lsRvalid), 32'(expLsRvalid));
    checkOutput("ls_err", 32'(lsErr), 32'(expLsErr));
    checkOutput("ls_rdata", lsRdata, expLsRdata);
    lastIfGnt = expIfGnt;
    lastLsGnt = expLsGnt;
    if (!rstV) begin
      lsStreak = 0;
      expIfRvalid = 0; expLsRvalid = 0; expLsErr = 0; expIfRdata = '0; expLsRdata = '0;
    end else begin
      if (!ifReqV || expIfGnt) lsStreak = 0;
      else if (expLsGnt && lsStreak < STARVE_LIMIT) lsStreak++;
      expIfRvalid = expIfGnt && !ifFlushV;
      if (expIfRvalid) expIfRdata = romWord(ifAddrV);
      expLsRvalid = expLsGnt;
      expLsErr    = expLsGnt && !lsOk;
      if (expLsGnt) expLsRdata = lsOk ? romWord(lsAddrV) : '0;
    end
  endtask

  initial begin
    string grantSeq;
    logic rIfReq, rLsReq;
    logic [ADDR_W-1:0] rIfAddr, rLsAddr;

    for (int i = 0; i < 256; i++) romMem[i] = $urandom;
    romMem[0] = 32'h3401_1100;
    romMem[1] = 32'h3402_0020;
    romMem[2] = 32'h3403_ff00;

    rst = 0; ifReq = 0; ifAddr = '0; ifFlush = 0; lsReq = 0; lsAddr = '0;
    repeat (2) @(posedge clk);
    lsStreak = 0;
    expIfRvalid = 0; expLsRvalid = 0; expLsErr = 0; expIfRdata = '0; expLsRdata = '0;

    $display("[TB] reset with both requesting");
    applyStimulus(0, 1, 32'h0, 0, 1, 32'h100);
    applyStimulus(0, 1, 32'h0, 0, 1, 32'h100);
    applyStimulus(1, 1, 32'h0, 0, 1, 32'h100);
    checkOutput("first_after_reset_ls", 32'(lastLsGnt), 32'd1);

    $display("[TB] IF-only sequential fetch");
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    applyStimulus(1, 1, 32'h0, 0, 0, 32'h0);
    applyStimulus(1, 1, 32'h4, 0, 0, 32'h0);
    checkOutput("fetch0_word", ifRdata, 32'h3401_1100);
    applyStimulus(1, 1, 32'h8, 0, 0, 32'h0);
    checkOutput("fetch1_word", ifRdata, 32'h3402_0020);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("fetch2_word", ifRdata, 32'h3403_ff00);

    $display("[TB] contention / starvation pattern");
    grantSeq = "";
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 1, 32'h0, 0, 1, 32'h100);
      grantSeq = {grantSeq, ifGnt ? "I" : (lsGnt ? "L" : "-")};
    end
    checkOutput("starve_pattern", 32'(grantSeq == "LLLILLLI"), 32'd1);

    $display("[TB] misaligned LS");
    applyStimulus(1, 0, 32'h0, 0, 1, 32'h102);
    checkOutput("mis_ce_off", 32'(romCe), 32'd0);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("mis_err", 32'(lsErr), 32'd1);

    $display("[TB] flush");
    applyStimulus(1, 1, 32'h20, 1, 0, 32'h0);
    applyStimulus(1, 1, 32'h40, 0, 0, 32'h0);
    checkOutput("flush_drop", 32'(ifRvalid), 32'd0);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("refetch_word", ifRdata, romMem[16]);

    $display("[TB] reset mid-access");
    applyStimulus(1, 0, 32'h0, 0, 1, 32'h10);
    applyStimulus(0, 0, 32'h0, 0, 1, 32'h10);
    applyStimulus(0, 0, 32'h0, 0, 0, 32'h0);
    checkOutput("midreset_rvalid", 32'(lsRvalid), 32'd0);
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0);

    $display("[TB] randomized traffic");
    rIfReq = 0; rLsReq = 0; rIfAddr = '0; rLsAddr = '0;
    for (int c = 0; c < 3000; c++) begin
      logic rstV;
      rstV = ($urandom_range(0, 99) != 0);
      if (!(rIfReq && !lastIfGnt) || !rstV) begin
        rIfReq  = ($urandom_range(0, 3) != 0);
        rIfAddr = ADDR_W'($urandom_range(0, 255)) << 2;
      end
      if (!(rLsReq && !lastLsGnt) || !rstV) begin
        rLsReq  = ($urandom_range(0, 2) == 0);
        rLsAddr = (ADDR_W'($urandom_range(0, 255)) << 2) |
                  (($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(1, 3)) : '0);
      end
      applyStimulus(rstV, rIfReq, rIfAddr, ($urandom_range(0, 9) == 0), rLsReq, rLsAddr);
      if (!rstV) begin
        rIfReq = 0; rLsReq = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
